// File: rtl/pe_feeder.sv
// pe_feeder: buffers a stream of packed complex samples and issues them to the
// PE data-load port as fixed-size bursts separated by a compute gap, repeating
// for a programmed number of iterations and flagging the last one with alpha_v.
// Optional build macro PE_FEEDER_STALL_CNT_EN adds a 16-bit saturating count of
// cycles spent waiting for the FIFO to hold a full burst.
module pe_feeder #(
    parameter int unsigned DW         = 32,
    parameter int unsigned BURST      = 16,
    parameter int unsigned FIFO_DEPTH = 32,
    parameter int unsigned GAP        = 24,
    parameter int unsigned ITER_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DW-1:0]     s_data,
    output logic              s_ready,
    input  logic              start,
    input  logic [ITER_W-1:0] num_iter,
    output logic              din_pe_v,
    output logic [DW-1:0]     din_pe,
    output logic              alpha_v,
    output logic              busy,
    output logic              done
`ifdef PE_FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [CW-1:0] DEPTH_LVL  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] BURST_LVL  = CW'(BURST);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_BURST,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state;
    logic [DW-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              push;
    logic              pop;
    logic [BW-1:0]     burst_cnt;
    logic [GW-1:0]     gap_cnt;
    logic [ITER_W-1:0] iters;
    logic [ITER_W-1:0] iter_idx;
    logic              last_iter;

    // FIFO handshake: ready comes straight from the registered occupancy
    assign s_ready   = (count < DEPTH_LVL);
    assign push      = s_valid & s_ready;
    assign pop       = (state == S_BURST);
    assign last_iter = ((iter_idx + ITER_W'(1)) == iters);

    // FIFO storage; contents need no reset since pointers gate every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Job sequencer: wait for a full burst, stream it, idle for the compute gap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            din_pe_v  <= 1'b0;
            din_pe    <= '0;
            alpha_v   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            iters     <= '0;
            iter_idx  <= '0;
            burst_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            din_pe_v <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        iters    <= (num_iter == '0) ? ITER_W'(1) : num_iter;
                        iter_idx <= '0;
                        busy     <= 1'b1;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (count >= BURST_LVL) begin
                        burst_cnt <= '0;
                        state     <= S_BURST;
                    end
                end
                S_BURST: begin
                    din_pe_v  <= 1'b1;
                    din_pe    <= mem[rd_ptr];
                    burst_cnt <= burst_cnt + BW'(1);
                    if ((burst_cnt == '0) && last_iter) begin
                        alpha_v <= 1'b1;
                    end
                    if (burst_cnt == BURST_LAST) begin
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + GW'(1);
                    if (gap_cnt == GAP_LAST) begin
                        iter_idx <= iter_idx + ITER_W'(1);
                        state    <= last_iter ? S_DONE : S_WAIT;
                    end
                end
                S_DONE: begin
                    done    <= 1'b1;
                    alpha_v <= 1'b0;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PE_FEEDER_STALL_CNT_EN
    // Saturating count of cycles spent waiting for data; cleared per job
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if ((state == S_IDLE) && start) begin
            stall_cnt <= '0;
        end else if ((state == S_WAIT) && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_feeder.sv
// Testbench for pe_feeder: timeline reference model checked every cycle,
// a table of whole-job vectors, and directed multi-cycle corner cases.
module tb_pe_feeder;

    localparam int DW    = 32;
    localparam int BURST = 16;
    localparam int FD    = 32;
    localparam int GAP   = 24;
    localparam int IW    = 8;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          s_valid  = 1'b0;
    logic [DW-1:0] s_data   = '0;
    logic          start    = 1'b0;
    logic [IW-1:0] num_iter = '0;
    logic          s_ready;
    logic          din_pe_v;
    logic [DW-1:0] din_pe;
    logic          alpha_v;
    logic          busy;
    logic          done;
`ifdef PE_FEEDER_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    pe_feeder #(
        .DW(DW), .BURST(BURST), .FIFO_DEPTH(FD), .GAP(GAP), .ITER_W(IW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .start(start),
        .num_iter(num_iter),
        .din_pe_v(din_pe_v),
        .din_pe(din_pe),
        .alpha_v(alpha_v),
        .busy(busy),
        .done(done)
`ifdef PE_FEEDER_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state: FIFO contents as a queue, job as a timeline
    logic [DW-1:0] q[$];
    int            cyc = 0;
    bit            busy_m = 0;
    int            iters_m = 0;
    int            iter_m = 0;
    int            burst_c = -1;
    int            t_start = 0;
    int            stall_m = 0;
    logic          e_v = 0;
    logic          e_alpha = 0;
    logic          e_done = 0;
    logic [DW-1:0] e_d = '0;

    int            checks = 0;
    int            errors = 0;

    bit            feeding = 0;
    int            feed_left = 0;
    logic [DW-1:0] feed_word = '0;

    typedef struct {
        int prefill;
        int extra;
        int niter;
        int exp_lat;
        int exp_v;
        int exp_alpha;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        q.delete();
        busy_m  = 0;
        burst_c = -1;
        stall_m = 0;
        e_v     = 0;
        e_alpha = 0;
        e_done  = 0;
        e_d     = '0;
    endtask

    // One clock edge of the job: burst begins on the first edge in which a full
    // burst is buffered; words leave on the next BURST edges; the following
    // check (or done) falls 1+BURST+GAP edges after the burst decision.
    task automatic model_step(input logic p, input logic [DW-1:0] d, input logic st,
                              input int ni, input int pre);
        int k;
        e_v    = 0;
        e_done = 0;
        if (busy_m) begin
            if (burst_c >= 0) begin
                k = cyc - burst_c;
                if (k >= 1 && k <= BURST) begin
                    e_d = q.pop_front();
                    e_v = 1;
                    if (k == 1 && iter_m == iters_m - 1) e_alpha = 1;
                end
                if (k == BURST + GAP + 1) begin
                    iter_m++;
                    if (iter_m == iters_m) begin
                        e_done  = 1;
                        e_alpha = 0;
                        busy_m  = 0;
                    end else begin
                        burst_c = -1;
                    end
                end
            end
            if (busy_m && burst_c < 0) begin
                if (stall_m < 65535) stall_m++;
                if (pre >= BURST) burst_c = cyc;
            end
        end else if (st) begin
            busy_m  = 1;
            iters_m = (ni == 0) ? 1 : ni;
            iter_m  = 0;
            burst_c = -1;
            stall_m = 0;
            t_start = cyc;
        end
        if (p) q.push_back(d);
    endtask

    task automatic compare_all();
        chk("din_pe_v", din_pe_v, e_v);
        chk("din_pe", din_pe, e_d);
        chk("alpha_v", alpha_v, e_alpha);
        chk("busy", busy, busy_m);
        chk("done", done, e_done);
        chk("s_ready", s_ready, (q.size() < FD));
`ifdef PE_FEEDER_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, stall_m);
`endif
    endtask

    task automatic tick();
        logic          p;
        logic [DW-1:0] d;
        logic          st;
        int            ni;
        int            pre;
        if (feeding) begin
            s_valid = (feed_left > 0);
            s_data  = feed_word;
        end
        pre = q.size();
        p   = s_valid && (pre < FD);
        d   = s_data;
        st  = start;
        ni  = int'(num_iter);
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0;
        model_step(p, d, st, ni, pre);
        compare_all();
        if (feeding && p) begin
            feed_left--;
            feed_word++;
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        start   = 1'b0;
        feeding = 0;
        #2;
        model_clear();
        chk("rst_din_pe_v", din_pe_v, 0);
        chk("rst_din_pe", din_pe, 0);
        chk("rst_alpha_v", alpha_v, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_s_ready", s_ready, 1);
`ifdef PE_FEEDER_STALL_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int lat, output int vcnt,
                             output int acnt, output logic [DW-1:0] first_w);
        bit seen;
        seen    = 0;
        lat     = -1;
        vcnt    = 0;
        acnt    = 0;
        first_w = '1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (din_pe_v) begin
                if (vcnt == 0) first_w = din_pe;
                vcnt++;
            end
            if (alpha_v) acnt++;
            if (done) begin
                lat  = cyc - t_start;
                seen = 1;
                break;
            end
        end
        chk("done_within_budget", seen, 1);
    endtask

    task automatic prefill(input int n);
        feeding   = 1;
        feed_word = 32'h0001_0000;
        feed_left = n;
        for (int i = 0; i < 200 && feed_left > 0; i++) tick();
        chk("prefill_accepted", feed_left, 0);
    endtask

    initial begin
        vec_t          vecs[4];
        int            lat;
        int            vcnt;
        int            acnt;
        int            vpre;
        int            dcnt;
        logic [DW-1:0] first_w;

        vecs[0] = '{16,  0, 1,  42, 16, 40};
        vecs[1] = '{32, 16, 3, 124, 48, 40};
        vecs[2] = '{16,  0, 0,  42, 16, 40};
        vecs[3] = '{32,  0, 2,  83, 32, 40};

        // Whole-job vectors from a fresh reset
        for (int v = 0; v < 4; v++) begin
            do_reset();
            prefill(vecs[v].prefill);
            feed_left = vecs[v].extra;
            num_iter  = IW'(vecs[v].niter);
            start     = 1'b1;
            tick();
            wait_done(1000, lat, vcnt, acnt, first_w);
            chk("vec_latency", lat, vecs[v].exp_lat);
            chk("vec_valid_cycles", vcnt, vecs[v].exp_v);
            chk("vec_alpha_cycles", acnt, vecs[v].exp_alpha);
            chk("vec_first_word", first_w, 32'h0001_0000);
            tick();
            chk("vec_busy_after_done", busy, 0);
        end

        // Underfilled FIFO: burst must wait for the late words
        do_reset();
        prefill(10);
        num_iter = 8'd1;
        start    = 1'b1;
        tick();
        vpre = 0;
        repeat (20) begin
            tick();
            if (din_pe_v) vpre++;
        end
        chk("no_early_burst", vpre, 0);
        feed_left = 6;
        wait_done(1000, lat, vcnt, acnt, first_w);
        chk("stall_latency", lat, 68);
        chk("stall_valid_cycles", vcnt, 16);
        chk("stall_first_word", first_w, 32'h0001_0000);
`ifdef PE_FEEDER_STALL_CNT_EN
        chk("stall_cnt_final", stall_cnt, 27);
`endif

        // Continuous push with no job: FIFO fills, then a job drains one burst
        do_reset();
        feeding   = 1;
        feed_word = 32'h0002_0000;
        feed_left = 40;
        repeat (40) tick();
        chk("s_ready_full", s_ready, 0);
        chk("accepted_until_full", 40 - feed_left, 32);
        feed_left = 0;
        num_iter  = 8'd1;
        start     = 1'b1;
        tick();
        wait_done(1000, lat, vcnt, acnt, first_w);
        chk("drain_latency", lat, 42);
        chk("drain_first_word", first_w, 32'h0002_0000);
        chk("s_ready_after_drain", s_ready, 1);

        // Reset while the 8th word of a burst is on the port
        num_iter = 8'd1;
        start    = 1'b1;
        tick();
        vcnt = 0;
        for (int i = 0; i < 100 && vcnt < 8; i++) begin
            tick();
            if (din_pe_v) vcnt++;
        end
        chk("reached_8th_word", vcnt, 8);
        do_reset();
        prefill(16);
        feed_left = 0;
        num_iter  = 8'd1;
        start     = 1'b1;
        tick();
        wait_done(1000, lat, vcnt, acnt, first_w);
        chk("post_rst_latency", lat, 42);
        chk("post_rst_valid_cycles", vcnt, 16);
        chk("post_rst_first_word", first_w, 32'h0001_0000);

        // num_iter=0 plus a start pulse while busy
        do_reset();
        prefill(16);
        num_iter = 8'd0;
        start    = 1'b1;
        tick();
        repeat (5) tick();
        num_iter = 8'd5;
        start    = 1'b1;
        tick();
        wait_done(1000, lat, vcnt, acnt, first_w);
        chk("busy_start_latency", lat, 42);
        dcnt = 0;
        repeat (60) begin
            tick();
            if (done) dcnt++;
        end
        chk("busy_start_single_done", dcnt, 0);

        // Randomized traffic and job requests against the model
        do_reset();
        feeding = 0;
        for (int i = 0; i < 4000; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = $urandom;
            if ($urandom_range(0, 39) == 0) begin
                start    = 1'b1;
                num_iter = IW'($urandom_range(0, 3));
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
